// File: rtl/alu_pkg.sv
// Shared constants for the ALU control pipeline: main-decoder op values,
// ALU codes and FSM state encoding.
package alu_pkg;

  // Main-decoder ALU op values
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_FUNC = 2'b00;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  // Function-field codes start at this opcode value
  localparam int FUNC_BASE = 2;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: maps (op, opcode) to a control code and
// flags anything outside the defined encodings as illegal (code forced to ADD).
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter int FUNC_W = 4,
  parameter int CTRL_W = 3
) (
  input  logic [1:0]        op,
  input  logic [FUNC_W-1:0] opcode,
  output logic [CTRL_W-1:0] code,
  output logic              illegal
);

  localparam int unsigned OPC_MAX = 2**CTRL_W + FUNC_BASE - 1;

  logic [31:0] opc_ext;

  assign opc_ext = 32'(opcode);

  always_comb begin
    code    = CTRL_W'(ALU_ADD);
    illegal = 1'b0;
    case (op)
      OP_ADD: code = CTRL_W'(ALU_ADD);
      OP_SUB: code = CTRL_W'(ALU_SUB);
      OP_FUNC: begin
        if (opc_ext >= 32'(FUNC_BASE) && opc_ext <= OPC_MAX)
          code = CTRL_W'(opc_ext - 32'(FUNC_BASE));
        else
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decode with valid/ready handshakes, optional
// multi-cycle hold-off per control code and a saturating illegal-decode counter.
module alu_ctrl_pipe
  import alu_pkg::*;
#(
  parameter int                    FUNC_W  = 4,
  parameter int                    CTRL_W  = 3,
  parameter logic [2**CTRL_W-1:0]  MC_MASK = 8'b1100_0000,
  parameter int                    MC_LAT  = 4,
  parameter int                    ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [FUNC_W-1:0] opcode,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = $clog2(MC_LAT);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CTRL_W-1:0] dec_code;
  logic              dec_illegal;
  logic              dec_mc;
  logic              accept;

  alu_ctrl_decode #(
    .FUNC_W (FUNC_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .op      (op),
    .opcode  (opcode),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  assign in_ready   = (state == ST_IDLE) || ((state == ST_VALID) && ctrl_ready);
  assign accept     = in_valid && in_ready;
  assign dec_mc     = MC_MASK[dec_code] && !dec_illegal;
  assign ctrl_valid = (state == ST_VALID);
  assign busy       = (state == ST_WAIT);

  // A new accept always wins over the VALID->IDLE drain, giving back-to-back issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ctrl    <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      ctrl    <= dec_code;
      illegal <= dec_illegal;
      if (dec_mc) begin
        state <= ST_WAIT;
        cnt   <= CNT_W'(MC_LAT - 1);
      end else begin
        state <= ST_VALID;
        cnt   <= '0;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_VALID;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_VALID: begin
          if (ctrl_ready)
            state <= ST_IDLE;
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (accept && dec_illegal && (err_cnt != {ERR_W{1'b1}}))
      err_cnt <= err_cnt + ERR_W'(1);
  end

endmodule

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface -- parameters
REQ-001 SHALL have parameter FUNC_W, default 4, opcode field width (at least CTRL_W+1).
REQ-002 SHALL have parameter CTRL_W, default 3, ALU control code width.
REQ-003 SHALL have parameter MC_MASK, default 8'b1100_0000, 2**CTRL_W-bit mask; bit k=1 marks control code k as multi-cycle.
REQ-004 SHALL have parameter MC_LAT, default 4, multi-cycle latency in clocks (at least 2).
REQ-005 SHALL have parameter ERR_W, default 8, illegal-decode counter width.

Interface -- ports
REQ-006 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, decode request present.
REQ-009 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-010 SHALL have port op, input, 2, main-decoder ALU op.
REQ-011 SHALL have port opcode, input, FUNC_W, function field.
REQ-012 SHALL have port ctrl_valid, output, 1, ctrl is valid.
REQ-013 SHALL have port ctrl_ready, input, 1, consumer takes ctrl when ctrl_valid && ctrl_ready.
REQ-014 SHALL have port ctrl, output, CTRL_W, registered ALU control code.
REQ-015 SHALL have port illegal, output, 1, current ctrl came from an illegal decode.
REQ-016 SHALL have port busy, output, 1, high in state WAIT.
REQ-017 SHALL have port err_cnt, output, ERR_W, saturating count of accepted illegal decodes.

Function
REQ-018 SHALL decode as follows: op=2'b10 gives code 0; op=2'b01 gives code 1; op=2'b00 with 2 <= opcode <= 2**CTRL_W+1 gives code opcode-2; any other op/opcode gives code 0 with illegal=1.
REQ-019 SHALL implement FSM states IDLE, WAIT and VALID.
REQ-020 SHALL, in IDLE on accept of a non-multi-cycle code, register ctrl/illegal and enter VALID, so ctrl_valid rises one cycle after accept.
REQ-021 SHALL, in IDLE on accept of a multi-cycle code (MC_MASK bit set, legal only), register ctrl, load the counter with MC_LAT-1 and enter WAIT.
REQ-022 SHALL, in WAIT, decrement the counter each cycle, enter VALID when the counter reaches 1, and thus raise ctrl_valid exactly MC_LAT cycles after accept.
REQ-023 SHALL, in VALID, hold ctrl/illegal stable while ctrl_ready=0.
REQ-024 SHALL, in VALID with ctrl_ready=1, return to IDLE, or accept a new request in the same cycle (back-to-back) and proceed per REQ-020/REQ-021.
REQ-025 SHALL drive in_ready = (state==IDLE) || (state==VALID && ctrl_ready), combinationally from state and ctrl_ready only.
REQ-026 SHALL ignore op/opcode when in_valid=0 or in_ready=0.
REQ-027 SHALL increment err_cnt once per accepted illegal request and saturate at all-ones.
REQ-028 SHALL force illegal decodes to be single-cycle regardless of MC_MASK bit 0.

Reset
REQ-029 SHALL, on rst asserted at any time including mid-WAIT, go to IDLE immediately with ctrl=0, illegal=0, ctrl_valid=0, busy=0, err_cnt=0 and counter=0.
REQ-030 SHALL drive in_ready=1 during and after reset, with the first accept on the first rising edge after rst deasserts.

Structure
REQ-031 SHALL place the FSM state encoding and ALU code constants (ADD=0, SUB=1) in shared package alu_pkg.
REQ-032 SHALL implement decode as combinational sub-module alu_ctrl_decode (op, opcode -> code, illegal), instanced once.
REQ-033 SHALL keep the FSM, counter and err_cnt in alu_ctrl_pipe.

Verification
REQ-034 SHALL check: op=10, ctrl_ready=1 -> ctrl=0, ctrl_valid high exactly 1 cycle after accept.
REQ-035 SHALL check: op=00, opcode=4'b1000 (code 6, multi-cycle) -> busy for 3 cycles, ctrl=6 valid at accept+4, in_ready=0 meanwhile.
REQ-036 SHALL check: op=00, opcode=4'b1111 -> ctrl=0, illegal=1, err_cnt 0->1; 300 illegal requests with ERR_W=8 -> err_cnt=255.
REQ-037 SHALL check: ctrl_ready=0 for 5 cycles in VALID -> ctrl stable, in_ready=0; then ctrl_ready=1 with new opcode=4'b0011 -> ctrl=1 next cycle, no bubble.
REQ-038 SHALL check: rst pulse at cycle 2 of WAIT -> ctrl_valid=0, busy=0 immediately, no late ctrl_valid afterwards.
